main_memory_responder: RTL and testbench
========================================

Name: main_memory_responder

Overview:
- Behavioural main-memory model that sits on the far side of the cache miss path and services the cache's `Access_MM` requests.
- Read requests return a refill block on `Data_MM` (1 or 2 words) after a fixed latency. Write requests update a single word.
- Gives the cache-configuration comparison runs a shared, cycle-deterministic miss penalty, and counts memory traffic so it can be checked against the caches' `CNT_MISS`.

Parameters:
- WORDS_PER_BLOCK, 1, refill block size in 32-bit words; legal values 1 or 2.
- LATENCY, 4, cycles from request acceptance to `MM_Ready`; must be >= 1.
- MEM_AW, 8, word-address bits; memory holds 2**MEM_AW words.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- Access_MM  input  1  request from cache; held high until `MM_Ready` is seen.
- MM_Write  input  1  1 = single-word write, 0 = block read; sampled at acceptance.
- MM_Addr  input  32  byte address; sampled at acceptance.
- MM_WData  input  32  write data; sampled at acceptance.
- MM_Busy  output  1  high while a request is accepted and not yet released.
- MM_Ready  output  1  one-cycle completion strobe.
- Data_MM  output  32*WORDS_PER_BLOCK  read block; word at lower address in bits [31:0].
- CNT_READ  output  20  accepted read requests, saturating.
- CNT_WRITE  output  20  accepted write requests, saturating.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; `MM_Busy`=0, `MM_Ready`=0, `Data_MM`=0, `CNT_READ`=0, `CNT_WRITE`=0.
  - Memory array is not cleared by reset.
- Memory initial content (time 0 only): word i = i*4, i.e. each word holds its own byte address.
- Address decode:
  - Word index = `MM_Addr[MEM_AW+1:2]`. Bits [1:0] are ignored, and bits above MEM_AW+1 are ignored (wrap-around).
  - Reads with WORDS_PER_BLOCK=2 clear word-index bit 0 (block aligned). Word b in the block comes from index base+b.
- States: IDLE, WAIT, ACK, RELEASE.
- IDLE:
  - If `Access_MM`=1 at edge k: latch addr, write flag and wdata; load cnt=LATENCY-1; go WAIT; `MM_Busy`=1 from k.
  - Increment `CNT_READ` or `CNT_WRITE` at k, holding at 20'hFFFFF.
- WAIT:
  - If cnt=0: perform the access and go ACK. For a read, `Data_MM` is registered with the block. For a write, mem[idx] is updated with the latched wdata.
  - Otherwise decrement cnt.
  - Result: `MM_Ready`=1 exactly in the cycle after edge k+LATENCY.
- ACK: `MM_Ready`=1 for this single cycle. Next state is RELEASE if `Access_MM`=1, else IDLE with `MM_Busy`=0.
- RELEASE: `MM_Ready`=0, `MM_Busy`=1; go IDLE when `Access_MM`=0. This 4-phase handshake prevents a held request being served twice.
- Input changes after acceptance are ignored: `MM_Addr`, `MM_Write` and `MM_WData` changes have no effect.
- Request withdrawn during WAIT: the access still completes, including the write, and `MM_Ready` still pulses.
- `Data_MM` holds its last read value through writes and idle cycles. It changes only on read completion or reset.
- Back-to-back requests: `Access_MM` low for at least one cycle, then high. The new request is accepted the first IDLE cycle it is high, giving minimum turnaround of LATENCY+2 cycles per request.
- Reset mid-operation: the transaction is aborted with no `MM_Ready`. A write not yet performed is discarded; a completed write persists.
- LATENCY=1: WAIT lasts one cycle, so `MM_Ready` is high in the cycle following the acceptance edge +1.

Test Plan:
- Reset release, WORDS=2: read 0x44 (`Access_MM` held, accepted edge k) -> `MM_Busy`=1 at k. `MM_Ready` high only in the cycle after edge k+4. `Data_MM`=64'h00000044_00000040. `CNT_READ`=1.
- Write 0x48 data 32'hDEADBEEF, then read 0x4C -> `MM_Ready` pulses once per request. Read returns {32'h0000004C, 32'hDEADBEEF}. `CNT_WRITE`=1, `CNT_READ`=1. `Data_MM` stays 0 during the write.
- `Access_MM` held 10 cycles past `MM_Ready` -> exactly one `MM_Ready` pulse; state RELEASE, `MM_Busy`=1 until `Access_MM` drops; `CNT_READ` increments once.
- `MM_Addr` changed from 0x10 to 0x20 during WAIT; `Access_MM` dropped in WAIT -> `Data_MM` = block at 0x10 (WORDS=1: 32'h00000010). `MM_Ready` still pulses, then IDLE directly.
- RESET asserted 2 cycles into a write of 32'h12345678 to 0x0 -> outputs zero immediately, no `MM_Ready`. A later read of 0x0 returns 32'h00000000.
- Address wrap, MEM_AW=8: read 0x404 with WORDS=1 -> returns 32'h00000004 (same word as 0x004). Counter saturation via forced preload 20'hFFFFF -> `CNT_READ` stays 20'hFFFFF after a read.

Source files
------------

// File: rtl/main_memory_responder.sv
// Behavioural main memory serving cache miss traffic with a fixed,
// cycle-deterministic latency and a 4-phase request/ready handshake.
// Also counts accepted reads and writes for cross-checking cache miss counts.
module main_memory_responder #(
  parameter int WORDS_PER_BLOCK = 1,
  parameter int LATENCY         = 4,
  parameter int MEM_AW          = 8
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         Access_MM,
  input  logic                         MM_Write,
  input  logic [31:0]                  MM_Addr,
  input  logic [31:0]                  MM_WData,
  output logic                         MM_Busy,
  output logic                         MM_Ready,
  output logic [32*WORDS_PER_BLOCK-1:0] Data_MM,
  output logic [19:0]                  CNT_READ,
  output logic [19:0]                  CNT_WRITE
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int BW    = 32 * WORDS_PER_BLOCK;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

  state_t              r_state, w_next;
  logic [MEM_AW-1:0]   r_idx;
  logic                r_write;
  logic [31:0]         r_wdata;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_data;
  logic [19:0]         r_cnt_read, r_cnt_write;

  // Storage is never reset. A word that has never been written reads as its
  // own byte address, which gives the power-up image without a preload pass.
  logic [31:0]         r_mem [DEPTH];
  logic [DEPTH-1:0]    r_written = '0;

  logic                w_accept, w_do_access;
  logic [MEM_AW-1:0]   w_base;
  logic [BW-1:0]       w_rblk;
  logic                w_unused_addr_bits;

  assign w_accept    = (r_state == S_IDLE) && Access_MM;
  assign w_do_access = (r_state == S_WAIT) && (r_cnt == '0);
  // Block reads are aligned to the block size; single-word writes are not.
  assign w_base      = (WORDS_PER_BLOCK == 2) ? {r_idx[MEM_AW-1:1], 1'b0} : r_idx;
  assign w_unused_addr_bits = ^{MM_Addr[31:MEM_AW+2], MM_Addr[1:0]};

  for (genvar b = 0; b < WORDS_PER_BLOCK; b++) begin : g_word
    logic [MEM_AW-1:0] w_ridx;
    assign w_ridx = w_base + MEM_AW'(b);
    assign w_rblk[b*32 +: 32] = r_written[w_ridx] ? r_mem[w_ridx] : 32'({w_ridx, 2'b00});
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next   = r_state;
    MM_Busy  = 1'b1;
    MM_Ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        MM_Busy = 1'b0;
        if (Access_MM) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_next = S_ACK;
      end
      S_ACK: begin
        MM_Ready = 1'b1;
        w_next   = Access_MM ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        if (!Access_MM) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, latency countdown and read-data register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      if (w_accept) begin
        r_idx   <= MM_Addr[MEM_AW+1:2];
        r_write <= MM_Write;
        r_wdata <= MM_WData;
        r_cnt   <= CW'(LATENCY - 1);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_do_access && !r_write) r_data <= w_rblk;
    end
  end

  // Traffic counters, saturating at all-ones
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt_read  <= '0;
      r_cnt_write <= '0;
    end else if (w_accept) begin
      if (MM_Write) begin
        if (r_cnt_write != 20'hFFFFF) r_cnt_write <= r_cnt_write + 20'd1;
      end else begin
        if (r_cnt_read != 20'hFFFFF) r_cnt_read <= r_cnt_read + 20'd1;
      end
    end
  end

  // Memory write; a reset before the access point discards the write
  always_ff @(posedge CLK) begin
    if (w_do_access && r_write && !RESET) begin
      r_mem[r_idx]     <= r_wdata;
      r_written[r_idx] <= 1'b1;
    end
  end

  assign Data_MM   = r_data;
  assign CNT_READ  = r_cnt_read;
  assign CNT_WRITE = r_cnt_write;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: two instances (2-word and 1-word blocks,
// same latency) share one request stream and are compared against a simple
// word-array memory model with request counters.
module tb_main_memory_responder;

  localparam int LAT = 4;

  logic        CLK, RESET, Access_MM, MM_Write;
  logic [31:0] MM_Addr, MM_WData;
  logic        busy2, rdy2, busy1, rdy1;
  logic [63:0] d2;
  logic [31:0] d1;
  logic [19:0] crd2, cwr2, crd1, cwr1;

  main_memory_responder #(.WORDS_PER_BLOCK(2), .LATENCY(LAT), .MEM_AW(8)) u2 (
    .CLK(CLK), .RESET(RESET), .Access_MM(Access_MM), .MM_Write(MM_Write),
    .MM_Addr(MM_Addr), .MM_WData(MM_WData), .MM_Busy(busy2), .MM_Ready(rdy2),
    .Data_MM(d2), .CNT_READ(crd2), .CNT_WRITE(cwr2));

  main_memory_responder #(.WORDS_PER_BLOCK(1), .LATENCY(LAT), .MEM_AW(8)) u1 (
    .CLK(CLK), .RESET(RESET), .Access_MM(Access_MM), .MM_Write(MM_Write),
    .MM_Addr(MM_Addr), .MM_WData(MM_WData), .MM_Busy(busy1), .MM_Ready(rdy1),
    .Data_MM(d1), .CNT_READ(crd1), .CNT_WRITE(cwr1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model
  logic [31:0] m_mem [256];
  logic [19:0] m_rd, m_wr;
  logic [63:0] m_d2;
  logic [31:0] m_d1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_cnt2"}, {44'd0, crd2, cwr2}, {44'd0, m_rd, m_wr});
    chk({tag, "_cnt1"}, {44'd0, crd1, cwr1}, {44'd0, m_rd, m_wr});
  endtask

  // One complete request. hold = cycles Access_MM stays high after the ready
  // strobe; drop = withdraw the request right after acceptance.
  task automatic req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input int hold, input bit drop);
    logic [7:0] idx, base;
    Access_MM = 1'b1; MM_Write = wr; MM_Addr = addr; MM_WData = wd;
    @(posedge CLK); #1;
    if (wr) m_wr = sat_inc(m_wr); else m_rd = sat_inc(m_rd);
    chk("busy_at_accept", {62'd0, busy2, busy1}, 64'd3);
    chk_counters("accept");
    // everything after acceptance must be ignored
    MM_Addr = $urandom; MM_Write = ~wr; MM_WData = $urandom;
    if (drop) Access_MM = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      @(posedge CLK); #1;
      chk("ready_timing", {62'd0, rdy2, rdy1}, (c == LAT) ? 64'd3 : 64'd0);
    end
    idx = addr[9:2];
    if (wr) m_mem[idx] = wd;
    else begin
      base = {idx[7:1], 1'b0};
      m_d2 = {m_mem[base + 8'd1], m_mem[base]};
      m_d1 = m_mem[idx];
    end
    chk("data2", d2, m_d2);
    chk("data1", {32'd0, d1}, {32'd0, m_d1});
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      chk("release_phase", {60'd0, rdy2, rdy1, busy2, busy1}, 64'b0011);
    end
    Access_MM = 1'b0;
    @(posedge CLK); #1;
    chk("back_idle", {60'd0, rdy2, rdy1, busy2, busy1}, 64'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'(i * 4);
    m_rd = '0; m_wr = '0; m_d2 = '0; m_d1 = '0;
    RESET = 1'b1; Access_MM = 1'b0; MM_Write = 1'b0; MM_Addr = '0; MM_WData = '0;
    #12;
    chk("reset_hs", {60'd0, rdy2, rdy1, busy2, busy1}, 64'd0);
    chk("reset_data", d2 | {32'd0, d1}, 64'd0);
    chk_counters("reset");
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    // first read: 2-word block {0x44,0x40}, 1-word 0x44
    req(1'b0, 32'h44, 32'h0, 0, 1'b0);
    chk("read44_block", d2, 64'h00000044_00000040);

    // write then read the neighbouring word of the same block
    req(1'b1, 32'h48, 32'hDEADBEEF, 0, 1'b0);
    chk("data_held_on_write", d2, 64'h00000044_00000040);
    req(1'b0, 32'h4C, 32'h0, 0, 1'b0);
    chk("read4c_block", d2, 64'h0000004C_DEADBEEF);

    // request held long after ready: served once
    req(1'b0, 32'h80, 32'h0, 10, 1'b0);
    // address changed and request dropped during the wait
    req(1'b0, 32'h10, 32'h0, 0, 1'b1);
    chk("read10_word", {32'd0, d1}, 64'h10);

    // reset two cycles into a write: aborted, no ready, write discarded
    Access_MM = 1'b1; MM_Write = 1'b1; MM_Addr = 32'h0; MM_WData = 32'h12345678;
    @(posedge CLK); #1;
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    m_rd = '0; m_wr = '0; m_d2 = '0; m_d1 = '0;
    chk("abort_hs", {60'd0, rdy2, rdy1, busy2, busy1}, 64'd0);
    chk("abort_data", d2 | {32'd0, d1}, 64'd0);
    chk_counters("abort");
    Access_MM = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge CLK); #1;
      chk("no_ready_after_abort", {62'd0, rdy2, rdy1}, 64'd0);
    end
    req(1'b0, 32'h0, 32'h0, 0, 1'b0);
    chk("write_discarded", {32'd0, d1}, 64'h0);

    // address wrap past 2**MEM_AW words
    req(1'b0, 32'h404, 32'h0, 0, 1'b0);
    chk("wrap_404", {32'd0, d1}, 64'h4);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      bit wr, dr;
      int hd;
      wr = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 3) == 0);
      hd = dr ? 0 : $urandom_range(0, 3);
      req(wr, {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0, 8'($urandom_range(0, 15)), 2'($urandom)},
          $urandom, hd, dr);
    end

    // counter saturation
    force u2.r_cnt_read = 20'hFFFFF;
    force u1.r_cnt_read = 20'hFFFFF;
    @(posedge CLK); #1;
    release u2.r_cnt_read;
    release u1.r_cnt_read;
    m_rd = 20'hFFFFF;
    @(posedge CLK); #1;
    chk_counters("preload");
    req(1'b0, 32'h8, 32'h0, 0, 1'b0);
    chk("sat_read", {44'd0, crd2}, 64'hFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
